unsigned_seq_div_rs: RTL

UNSIGNED_SEQ_DIV_RS -- requirements
Module: unsigned_seq_div_rs

---
 rtl/unsigned_seq_div_rs_if.sv | 23 ++
 rtl/unsigned_seq_div_rs.sv | 109 ++++++++++
 2 files changed

// File: rtl/unsigned_seq_div_rs_if.sv
// unsigned_seq_div_rs_if -- operand/result bundle for the sequential divider.
//   load      : start request (master -> slave)
//   a, b      : 12-bit dividend, 6-bit divisor (master -> slave)
//   quotient  : 6-bit registered quotient (slave -> master)
//   remainder : 6-bit registered remainder (slave -> master)
//   busy      : divider is stepping
//   done      : result available, held until the next accepted load
//   err       : divide-by-zero / quotient overflow (only with SEQ_DIV_ERR_CHECK_EN)
interface unsigned_seq_div_rs_if;
   logic        load;
   logic [11:0] a;
   logic [5:0]  b;
   logic [5:0]  quotient;
   logic [5:0]  remainder;
   logic        busy;
   logic        done;
   logic        err;

   modport master (output load, a, b,
                   input  quotient, remainder, busy, done, err);
   modport slave  (input  load, a, b,
                   output quotient, remainder, busy, done, err);
endinterface

// File: rtl/unsigned_seq_div_rs.sv
// unsigned_seq_div_rs -- 12/6 unsigned restoring divider, one step per clock.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : unsigned_seq_div_rs_if.slave (load, a, b in; quotient, remainder,
//         busy, done, err out)
// A load accepted in IDLE or DONE latches the operands; six restoring steps
// follow, and the result registers update only on the last step.
// Optional macro SEQ_DIV_ERR_CHECK_EN: loads with b==0 or a[11:6]>=b skip the
// steps and finish immediately with err=1, quotient=6'h3F, remainder=0.
// Without it err is tied low and every load runs the full six steps.
module unsigned_seq_div_rs (
   input  logic                 clk,
   input  logic                 rst,
   unsigned_seq_div_rs_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state, state_nx;
   logic [6:0] p;
   logic [5:0] q, d;
   logic [2:0] cnt;
   logic [5:0] quo_r, rem_r;
   logic       accept, last, bad;
   logic [6:0] p_sh, p_nx;
   logic [5:0] q_sh, q_nx;
   logic [7:0] t;

   assign accept = bus.load && (state != RUN);
   assign last   = (cnt == 3'd5);

`ifdef SEQ_DIV_ERR_CHECK_EN
   logic err_r;
   // Quotient fits in 6 bits only when the upper dividend half is below b.
   assign bad     = (bus.b == 6'd0) || (bus.a[11:6] >= bus.b);
   assign bus.err = err_r;
`else
   assign bad     = 1'b0;
   assign bus.err = 1'b0;
`endif

   // One restoring step. P[6] is always 0 entering a step (P < D), so the
   // shifted partial remainder fits in 7 bits.
   always_comb begin
      p_sh = {p[5:0], q[5]};
      q_sh = {q[4:0], 1'b0};
      t    = {1'b0, p_sh} - {2'b00, d};
      p_nx = p_sh;
      q_nx = q_sh;
      if (!t[7]) begin
         p_nx    = t[6:0];
         q_nx[0] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (bus.load) state_nx = bad ? DONE : RUN;
         RUN:        if (last)     state_nx = DONE;
         default:                  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         p     <= '0;
         q     <= '0;
         d     <= '0;
         cnt   <= '0;
         quo_r <= '0;
         rem_r <= '0;
`ifdef SEQ_DIV_ERR_CHECK_EN
         err_r <= 1'b0;
`endif
      end else if (accept) begin
         p   <= {1'b0, bus.a[11:6]};
         q   <= bus.a[5:0];
         d   <= bus.b;
         cnt <= '0;
`ifdef SEQ_DIV_ERR_CHECK_EN
         err_r <= bad;
         if (bad) begin
            quo_r <= 6'h3F;
            rem_r <= 6'h00;
         end
`endif
      end else if (state == RUN) begin
         p   <= p_nx;
         q   <= q_nx;
         cnt <= cnt + 3'd1;
         // Results are published only on the final step so an aborted run
         // never exposes a partial value.
         if (last) begin
            quo_r <= q_nx;
            rem_r <= p_nx[5:0];
         end
      end
   end

   assign bus.quotient  = quo_r;
   assign bus.remainder = rem_r;
   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
endmodule
